download_flit_assembler: RTL and testbench

//  Receive end of the ring-NI flit protocol: accepts 16-bit flits one per cycle from the ring

---
 rtl/ring_flit_pkg.sv | 41 ++++
 rtl/download_datapath.sv | 84 ++++++++
 rtl/download_flit_assembler.sv | 108 ++++++++++
 tb/tb_download_flit_assembler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_flit_pkg.sv
// Shared ring-NI flit definitions: head field positions, length classes,
// flit indices within a message and the download FSM state encoding.
package ring_flit_pkg;

    localparam int FLIT_W = 16;

    localparam int DEST_HI = 15;
    localparam int DEST_LO = 14;
    localparam int SRC_HI  = 13;
    localparam int SRC_LO  = 12;
    localparam int LEN_HI  = 11;
    localparam int LEN_LO  = 10;

    typedef enum logic [1:0] {
        LEN_HEAD = 2'b00,
        LEN_ADDR = 2'b01,
        LEN_DATA = 2'b10,
        LEN_RSVD = 2'b11
    } len_e;

    localparam logic [3:0] IDX_HEAD   = 4'd0;
    localparam logic [3:0] IDX_ADDRHI = 4'd1;
    localparam logic [3:0] IDX_ADDRLO = 4'd2;
    localparam logic [3:0] IDX_DATA0  = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BODY = 2'b01,
        HOLD = 2'b10
    } state_e;

    // Index of the last flit of a message; the reserved class collapses to head-only.
    function automatic logic [3:0] len_to_max(input logic [1:0] len, input int data_flits);
        case (len_e'(len))
            LEN_ADDR: len_to_max = IDX_ADDRLO;
            LEN_DATA: len_to_max = 4'(int'(IDX_ADDRLO) + data_flits);
            default:  len_to_max = IDX_HEAD;
        endcase
    endfunction

endpackage

// File: rtl/download_datapath.sv
// Flit storage for the download path: head/address/data registers, the flit
// counter and the last-index register, steered by strobes from the FSM.
module download_datapath
    import ring_flit_pkg::*;
#(
    parameter int DATA_FLITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FLIT_W-1:0]             flit_in,
    input  logic                          head_load,
    input  logic                          flit_load,
    input  logic                          cnt_inc,
    input  logic                          cnt_clr,
    output logic [FLIT_W-1:0]             head_out,
    output logic [FLIT_W-1:0]             addrhi_out,
    output logic [FLIT_W-1:0]             addrlo_out,
    output logic [DATA_FLITS*FLIT_W-1:0]  data_out,
    output logic                          cnt_eq_max
);

    logic [FLIT_W-1:0] head_q, head_d;
    logic [FLIT_W-1:0] addrhi_q, addrhi_d;
    logic [FLIT_W-1:0] addrlo_q, addrlo_d;
    logic [DATA_FLITS-1:0][FLIT_W-1:0] data_q, data_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] max_q, max_d;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        head_d   = head_q;
        addrhi_d = addrhi_q;
        addrlo_d = addrlo_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        max_d    = max_q;

        if (head_load) begin
            // A new head wipes the previous message so short messages read 0 beyond their length.
            head_d   = flit_in;
            addrhi_d = '0;
            addrlo_d = '0;
            data_d   = '0;
            max_d    = len_to_max(flit_in[LEN_HI:LEN_LO], DATA_FLITS);
            cnt_d    = (max_d == IDX_HEAD) ? IDX_HEAD : IDX_ADDRHI;
        end else if (flit_load) begin
            if (cnt_q == IDX_ADDRHI) addrhi_d = flit_in;
            if (cnt_q == IDX_ADDRLO) addrlo_d = flit_in;
            for (int k = 0; k < DATA_FLITS; k++) begin
                if (cnt_q == 4'(int'(IDX_DATA0) + k)) data_d[k] = flit_in;
            end
        end

        if (cnt_clr)      cnt_d = '0;
        else if (cnt_inc) cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        // NOTE: the data array is cleared on reset too; it drives data_out directly and must read 0.
        if (rst) begin
            head_q   <= '0;
            addrhi_q <= '0;
            addrlo_q <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            max_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its _d from the same edge.
            head_q   <= head_d;
            addrhi_q <= addrhi_d;
            addrlo_q <= addrlo_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
        end
    end

    assign head_out   = head_q;
    assign addrhi_out = addrhi_q;
    assign addrlo_out = addrlo_q;
    assign data_out   = data_q;
    assign cnt_eq_max = (cnt_q == max_q);

endmodule

// File: rtl/download_flit_assembler.sv
// Receive side of the ring-NI flit protocol: reassembles head/addr/data flits
// into one message and offers it to the controller on a valid/ready handshake.
module download_flit_assembler
    import ring_flit_pkg::*;
#(
    parameter logic [1:0] NODE_ID    = 2'b00,
    parameter int         DATA_FLITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FLIT_W-1:0]             flit_in,
    input  logic                          flit_in_valid,
    output logic                          flit_in_ready,
    output logic                          msg_valid,
    input  logic                          msg_ready,
    output logic [FLIT_W-1:0]             head_out,
    output logic [FLIT_W-1:0]             addrhi_out,
    output logic [FLIT_W-1:0]             addrlo_out,
    output logic [DATA_FLITS*FLIT_W-1:0]  data_out,
    output logic [1:0]                    msg_len_out,
    output logic                          dest_err,
    output logic                          len_err
);

    state_e state_q, state_d;
    logic   dest_err_q, dest_err_d;
    logic   len_err_q, len_err_d;

    logic   xfer;
    logic   head_load, flit_load, cnt_inc, cnt_clr;
    logic   cnt_eq_max;
    logic   head_only;

    assign flit_in_ready = (state_q == IDLE) || (state_q == BODY);
    assign msg_valid     = (state_q == HOLD);
    assign xfer          = flit_in_valid && flit_in_ready;
    assign head_only     = (len_to_max(flit_in[LEN_HI:LEN_LO], DATA_FLITS) == IDX_HEAD);

    always_comb begin
        state_d    = state_q;
        head_load  = 1'b0;
        flit_load  = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        dest_err_d = 1'b0;
        len_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    head_load  = 1'b1;
                    dest_err_d = (flit_in[DEST_HI:DEST_LO] != NODE_ID);
                    len_err_d  = (flit_in[LEN_HI:LEN_LO] == LEN_RSVD);
                    state_d    = head_only ? HOLD : BODY;
                end
            end
            BODY: begin
                if (xfer) begin
                    flit_load = 1'b1;
                    // The last flit leaves cnt at max, so it never runs past the message.
                    if (cnt_eq_max) state_d = HOLD;
                    else            cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (msg_ready) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dest_err_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_err_q <= dest_err_d;
            len_err_q  <= len_err_d;
        end
    end

    assign dest_err    = dest_err_q;
    assign len_err     = len_err_q;
    assign msg_len_out = head_out[LEN_HI:LEN_LO];

    download_datapath #(
        .DATA_FLITS (DATA_FLITS)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .flit_in    (flit_in),
        .head_load  (head_load),
        .flit_load  (flit_load),
        .cnt_inc    (cnt_inc),
        .cnt_clr    (cnt_clr),
        .head_out   (head_out),
        .addrhi_out (addrhi_out),
        .addrlo_out (addrlo_out),
        .data_out   (data_out),
        .cnt_eq_max (cnt_eq_max)
    );

endmodule

// File: tb/tb_download_flit_assembler.sv
// Directed bench for download_flit_assembler: head-only, addr and data messages,
// backpressure, error pulses and mid-message reset.
module tb_download_flit_assembler;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  flit_in;
    logic         flit_in_valid;
    logic         flit_in_ready;
    logic         msg_valid;
    logic         msg_ready;
    logic [15:0]  head_out;
    logic [15:0]  addrhi_out;
    logic [15:0]  addrlo_out;
    logic [127:0] data_out;
    logic [1:0]   msg_len_out;
    logic         dest_err;
    logic         len_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    download_flit_assembler #(
        .NODE_ID    (2'b00),
        .DATA_FLITS (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flit_in       (flit_in),
        .flit_in_valid (flit_in_valid),
        .flit_in_ready (flit_in_ready),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .head_out      (head_out),
        .addrhi_out    (addrhi_out),
        .addrlo_out    (addrlo_out),
        .data_out      (data_out),
        .msg_len_out   (msg_len_out),
        .dest_err      (dest_err),
        .len_err       (len_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] f);
        flit_in       = f;
        flit_in_valid = 1'b1;
        step();
    endtask

    task automatic handshake();
        flit_in_valid = 1'b0;
        msg_ready     = 1'b1;
        step();
        msg_ready     = 1'b0;
        check("handshake_idle_valid", 128'(msg_valid), 128'(0));
        check("handshake_idle_ready", 128'(flit_in_ready), 128'(1));
    endtask

    logic [127:0] data_exp;

    initial begin
        rst           = 1'b1;
        flit_in       = 16'h0;
        flit_in_valid = 1'b0;
        msg_ready     = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_msg_valid", 128'(msg_valid), 128'(0));
        check("rst_head",      128'(head_out), 128'(0));
        check("rst_data",      data_out, 128'(0));
        check("rst_ready",     128'(flit_in_ready), 128'(1));
        check("rst_errs",      128'({dest_err, len_err}), 128'(0));

        // 1: head-only message
        send(16'h0012);
        flit_in_valid = 1'b0;
        check("t1_msg_valid", 128'(msg_valid), 128'(1));
        check("t1_head",      128'(head_out), 128'h0012);
        check("t1_addr",      128'({addrhi_out, addrlo_out}), 128'(0));
        check("t1_data",      data_out, 128'(0));
        check("t1_len",       128'(msg_len_out), 128'(0));
        check("t1_errs",      128'({dest_err, len_err}), 128'(0));
        check("t1_ready",     128'(flit_in_ready), 128'(0));
        handshake();

        // 2: address message, back to back
        send(16'h0400);
        send(16'hABCD);
        check("t2_not_yet", 128'(msg_valid), 128'(0));
        send(16'h1234);
        flit_in_valid = 1'b0;
        check("t2_msg_valid", 128'(msg_valid), 128'(1));
        check("t2_addrhi",    128'(addrhi_out), 128'hABCD);
        check("t2_addrlo",    128'(addrlo_out), 128'h1234);
        check("t2_data",      data_out, 128'(0));
        check("t2_len",       128'(msg_len_out), 128'(1));
        handshake();

        // 3: data message with valid toggled every other cycle
        send(16'h0800);
        flit_in_valid = 1'b0;
        step();
        send(16'h5555);
        flit_in_valid = 1'b0;
        step();
        send(16'h6666);
        flit_in_valid = 1'b0;
        step();
        for (int k = 1; k <= 8; k++) begin
            check("t3_not_yet", 128'(msg_valid), 128'(0));
            send(16'(k));
            flit_in_valid = 1'b0;
            step();
        end
        data_exp = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        check("t3_msg_valid", 128'(msg_valid), 128'(1));
        check("t3_head",      128'(head_out), 128'h0800);
        check("t3_addr",      128'({addrhi_out, addrlo_out}), 128'h5555_6666);
        check("t3_data_lo",   128'(data_out[15:0]), 128'h0001);
        check("t3_data_hi",   128'(data_out[127:112]), 128'h0008);
        check("t3_data",      data_out, data_exp);
        check("t3_len",       128'(msg_len_out), 128'(2));

        // 4: backpressure with the next head already waiting
        flit_in       = 16'h0012;
        flit_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t4_stall_ready", 128'(flit_in_ready), 128'(0));
            check("t4_stall_valid", 128'(msg_valid), 128'(1));
            check("t4_stall_data",  data_out, data_exp);
            check("t4_stall_head",  128'(head_out), 128'h0800);
        end
        msg_ready = 1'b1;
        step();
        msg_ready = 1'b0;
        check("t4_idle_valid", 128'(msg_valid), 128'(0));
        check("t4_idle_ready", 128'(flit_in_ready), 128'(1));
        step();
        flit_in_valid = 1'b0;
        check("t4_next_valid", 128'(msg_valid), 128'(1));
        check("t4_next_head",  128'(head_out), 128'h0012);
        check("t4_next_data",  data_out, 128'(0));
        handshake();

        // 5: wrong destination and reserved length
        send(16'hCC00);
        flit_in_valid = 1'b0;
        check("t5_dest_err",  128'(dest_err), 128'(1));
        check("t5_len_err",   128'(len_err), 128'(1));
        check("t5_msg_valid", 128'(msg_valid), 128'(1));
        check("t5_head",      128'(head_out), 128'hCC00);
        check("t5_len",       128'(msg_len_out), 128'(3));
        step();
        check("t5_pulse_end", 128'({dest_err, len_err}), 128'(0));
        check("t5_hold",      128'(msg_valid), 128'(1));
        handshake();

        // 6: reset after five flits of a data message
        send(16'h0800);
        send(16'hA001);
        send(16'hA002);
        send(16'h0011);
        send(16'h0022);
        flit_in_valid = 1'b0;
        check("t6_partial", 128'(data_out[31:0]), 128'h0022_0011);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", 128'(msg_valid), 128'(0));
        check("t6_rst_ready", 128'(flit_in_ready), 128'(1));
        check("t6_rst_regs",  128'({head_out, addrhi_out, addrlo_out, msg_len_out}), 128'(0));
        check("t6_rst_data",  data_out, 128'(0));
        step();
        check("t6_no_msg",    128'(msg_valid), 128'(0));
        send(16'h0000);
        flit_in_valid = 1'b0;
        check("t6_msg_valid", 128'(msg_valid), 128'(1));
        check("t6_data",      data_out, 128'(0));
        check("t6_head_addr", 128'({head_out, addrhi_out, addrlo_out}), 128'(0));
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
